inst_encoder_loader: RTL and testbench
======================================

Name: inst_encoder_loader

Overview:
- Encodes RV32I instruction fields into 32-bit instruction words and writes them sequentially into instruction memory.
- It is the encoder counterpart of the control-unit opcode decoder. It produces exactly the four formats that decoder consumes: R-type (opcode[6:2]=01100), LOAD (00000), STORE (01000) and BRANCH (11000).
- Sits between the test/boot program source and the instruction memory write port. Uses a valid/ready input handshake and a single-cycle memory write strobe.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- DEPTH, 256, maximum words per program; must be ≤ 2**ADDR_W.
- BASE_ADDR, 0, word address of the first written instruction.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begins a load session; honoured only in IDLE.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  block can accept a bundle.
- in_last  input  1  marks the final instruction of the program; qualified by in_valid.
- fmt  input  2  format select: 00 R, 01 LOAD, 10 STORE, 11 BRANCH.
- funct3  input  3  funct3 field.
- funct7  input  7  funct7 field; R-type only.
- rd  input  5  destination register.
- rs1  input  5  source register 1.
- rs2  input  5  source register 2.
- imm  input  13  immediate. Bits [11:0] are used by LOAD/STORE; the full 13 bits are used by BRANCH.
- imem_we  output  1  one-cycle write strobe.
- imem_addr  output  ADDR_W  word address.
- imem_wdata  output  32  encoded instruction.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse at session end.
- full  output  1  DEPTH words written; sticky until next start.
- count  output  ADDR_W+1  words written this session.
- err_align  output  1  sticky flag: a BRANCH was accepted with imm[0]=1; cleared by start.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. Outputs: in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, busy=0, done=0, full=0, count=0, err_align=0. A reset mid-session aborts the session immediately; partial memory contents are left as written.
- FSM states: IDLE, ACCEPT, WRITE, FINISH.
- IDLE, start=1:
  - clear count, full and err_align;
  - set the address register to BASE_ADDR;
  - go to ACCEPT.
- ACCEPT:
  - in_ready=1.
  - On in_valid&in_ready: register the encoded word and in_last, then go to WRITE.
  - start is ignored in this state.
- WRITE:
  - in_ready=0, imem_we=1, imem_addr = current address, imem_wdata = registered word.
  - Next edge: address+1 (wraps modulo 2**ADDR_W) and count+1.
  - If the registered last flag is set, or count+1==DEPTH, go to FINISH. In the DEPTH case, also set full=1.
  - Otherwise return to ACCEPT.
- FINISH: done=1 for exactly one cycle, then go to IDLE.
- Timing: the word accepted at edge N appears on imem_we/imem_wdata in cycle N+1. Maximum throughput is one instruction every 2 cycles.
- Encoding (combinational from inputs, registered on accept):
  - R: {funct7, rs2, rs1, funct3, rd, 7'b0110011}
  - LOAD: {imm[11:0], rs1, funct3, rd, 7'b0000011}
  - STORE: {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011}
  - BRANCH: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011}
- Unused fields per format are ignored. imm[12] is ignored for LOAD/STORE.
- BRANCH with imm[0]=1: the word is still written with imm[0] dropped, and err_align is set (sticky).
- in_valid while in_ready=0: the bundle is not consumed and the source must hold it.
- in_last together with count+1==DEPTH: FINISH is entered once and full=1.
- imem_we is never asserted outside WRITE.

Test Plan:
- Reset then start, send R fmt funct7=0 rs2=2 rs1=1 funct3=0 rd=3 with in_last=1 → one cycle later imem_we=1, addr=0, wdata=0x002081B3. Next cycle done=1 and count=1. Then IDLE with busy=0.
- Back-to-back bundles LOAD (rd=5 rs1=2 funct3=2 imm=8) then STORE (rs2=6 rs1=2 funct3=2 imm=12, last) → writes 0x00812283 at addr 0 and 0x00612623 at addr 1. in_ready is low during each WRITE cycle.
- BRANCH rs1=1 rs2=2 funct3=0 imm=-4 (13'h1FFC) → wdata=0xFE208EE3 and err_align stays 0. A second session with imm=13'h0005 → err_align=1 until the next start clears it.
- ADDR_W=2, DEPTH=4, send 6 bundles without in_last → exactly 4 writes at addrs 0..3, then full=1, count=4, one done pulse. Bundles 5 and 6 are not accepted (in_ready=0).
- Assert rst_n=0 in the cycle imem_we=1 during a 3-word session → all outputs return to reset values asynchronously. A fresh start then writes from BASE_ADDR with count=0.
- Pulse start while in ACCEPT and during WRITE → no state or address change; the session continues normally.

Source files
------------

// File: rtl/inst_encoder_loader.sv
// RV32I instruction encoder that streams encoded R/LOAD/STORE/BRANCH words
// into instruction memory, one word per accepted field bundle.
module inst_encoder_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [1:0]        fmt,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [12:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              err_align
);

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, FINISH} state_t;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

  state_t              state_q;
  logic [31:0]         word_q;
  logic                last_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W:0]     count_q;
  logic [ADDR_W:0]     count_d;
  logic                full_q;
  logic                err_q;
  logic                we_q;
  logic                ready_q;
  logic                busy_q;
  logic                done_q;
  logic [31:0]         enc_word_c;

  // Field packing for the four formats the control-unit decoder understands.
  always_comb begin
    enc_word_c = 32'h0;
    unique case (fmt)
      2'b00: enc_word_c = {funct7, rs2, rs1, funct3, rd, 7'b0110011};
      2'b01: enc_word_c = {imm[11:0], rs1, funct3, rd, 7'b0000011};
      2'b10: enc_word_c = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
      2'b11: enc_word_c = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
      default: enc_word_c = 32'h0;
    endcase
  end

  always_comb count_d = count_q + (ADDR_W+1)'(1);

  // Session FSM; every output is a flop updated on the transition into its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= 32'h0;
      last_q  <= 1'b0;
      addr_q  <= BASE_C;
      count_q <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= ACCEPT;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= BASE_C;
          end
        end
        ACCEPT: begin
          if (in_valid && ready_q) begin
            word_q  <= enc_word_c;
            last_q  <= in_last;
            ready_q <= 1'b0;
            we_q    <= 1'b1;
            state_q <= WRITE;
            if (fmt == 2'b11 && imm[0]) err_q <= 1'b1;
          end
        end
        WRITE: begin
          we_q    <= 1'b0;
          addr_q  <= addr_q + ADDR_W'(1);
          count_q <= count_d;
          if (last_q || count_d == DEPTH_C) begin
            state_q <= FINISH;
            done_q  <= 1'b1;
            if (count_d == DEPTH_C) full_q <= 1'b1;
          end else begin
            state_q <= ACCEPT;
            ready_q <= 1'b1;
          end
        end
        FINISH: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = word_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign full       = full_q;
  assign count      = count_q;
  assign err_align  = err_q;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed plus randomized bench for inst_encoder_loader, checked against an
// arithmetic encoder model and a simple session model.
module tb_inst_encoder_loader;

  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 10;
  localparam int unsigned BASE  = 13;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [1:0]    fmt;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic [4:0]    rd, rs1, rs2;
  logic [12:0]   imm;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          busy, done, full, err_align;
  logic [AW:0]   count;

  int vectors = 0;
  int miscompares = 0;

  int unsigned m_addr;
  int unsigned m_count;
  bit          m_full;
  bit          m_err;

  inst_encoder_loader #(.ADDR_W(AW), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .fmt(fmt), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1),
    .rs2(rs2), .imm(imm), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .full(full), .count(count), .err_align(err_align)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction words built by shifting and adding fields at their bit positions.
  function automatic logic [31:0] ref_enc(input int unsigned f, input int unsigned f3,
      input int unsigned f7, input int unsigned d, input int unsigned s1,
      input int unsigned s2, input int unsigned im);
    int unsigned w;
    w = (f3 << 12) + (s1 << 15);
    case (f)
      0: w += 32'h33 + (d << 7) + (s2 << 20) + (f7 << 25);
      1: w += 32'h03 + (d << 7) + ((im % 4096) << 20);
      2: w += 32'h23 + ((im % 32) << 7) + (s2 << 20) + (((im / 32) % 128) << 25);
      default: w += 32'h63 + (((im / 2048) % 2) << 7) + (((im / 2) % 16) << 8)
                     + (s2 << 20) + (((im / 32) % 64) << 25) + (((im / 4096) % 2) << 31);
    endcase
    return w;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 32'(in_ready), 0);
    chk({tag, "_we"},    32'(imem_we), 0);
    chk({tag, "_addr"},  32'(imem_addr), BASE);
    chk({tag, "_wdata"}, imem_wdata, 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_full"},  32'(full), 0);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_err"},   32'(err_align), 0);
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    m_addr = BASE; m_count = 0; m_full = 0; m_err = 0;
    chk({tag, "_busy"},  32'(busy), 1);
    chk({tag, "_ready"}, 32'(in_ready), 1);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_full"},  32'(full), 0);
    chk({tag, "_err"},   32'(err_align), 0);
  endtask

  // Offer one bundle, follow it through WRITE (and FINISH when the session ends).
  task automatic send(input string tag, input int unsigned f, input int unsigned f3,
      input int unsigned f7, input int unsigned d, input int unsigned s1,
      input int unsigned s2, input int unsigned im, input bit last, input bit inj_start,
      input bit use_want, input logic [31:0] want, output bit fin);
    logic [31:0] exp;
    int n;
    fmt = 2'(f); funct3 = 3'(f3); funct7 = 7'(f7); rd = 5'(d); rs1 = 5'(s1);
    rs2 = 5'(s2); imm = 13'(im); in_last = last; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 8) begin tick(); n++; end
    if (!in_ready) begin
      chk({tag, "_ready_timeout"}, 32'(in_ready), 1);
      in_valid = 1'b0; fin = 1'b1;
      return;
    end
    exp = use_want ? want : ref_enc(f, f3, f7, d, s1, s2, im);
    if (f == 3 && (im % 2) == 1) m_err = 1;
    start = inj_start;
    tick();
    in_valid = 1'b0;
    fmt = 2'($urandom); rd = 5'($urandom); imm = 13'($urandom); in_last = 1'($urandom);
    chk({tag, "_we"},    32'(imem_we), 1);
    chk({tag, "_addr"},  32'(imem_addr), m_addr);
    chk({tag, "_wdata"}, imem_wdata, exp);
    chk({tag, "_ready_w"}, 32'(in_ready), 0);
    chk({tag, "_err"},   32'(err_align), 32'(m_err));
    tick();
    start = 1'b0;
    m_addr = (m_addr + 1) % (1 << AW);
    m_count++;
    if (m_count == DEPTH) m_full = 1;
    fin = last || (m_count == DEPTH);
    chk({tag, "_we_off"}, 32'(imem_we), 0);
    chk({tag, "_count"},  32'(count), m_count);
    chk({tag, "_full"},   32'(full), 32'(m_full));
    chk({tag, "_done"},   32'(done), 32'(fin));
    if (fin) begin
      chk({tag, "_ready_f"}, 32'(in_ready), 0);
      tick();
      chk({tag, "_done_end"}, 32'(done), 0);
      chk({tag, "_busy_end"}, 32'(busy), 0);
    end else begin
      chk({tag, "_ready_back"}, 32'(in_ready), 1);
    end
  endtask

  // Bundles offered after a full session must never be taken or written.
  task automatic overflow_probe(input string tag);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk({tag, "_ready"}, 32'(in_ready), 0);
      chk({tag, "_we"},    32'(imem_we), 0);
    end
    in_valid = 1'b0;
    chk({tag, "_full"},  32'(full), 1);
    chk({tag, "_count"}, 32'(count), DEPTH);
  endtask

  initial begin
    bit fin;
    int unsigned len, f, im;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    fmt = 0; funct3 = 0; funct7 = 0; rd = 0; rs1 = 0; rs2 = 0; imm = 0;
    m_addr = BASE; m_count = 0; m_full = 0; m_err = 0;
    tick(); tick();
    chk_reset("reset");
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk_reset("idle");

    do_start("s1");
    send("r_add", 0, 0, 0, 3, 1, 2, 0, 1, 0, 1, 32'h002081B3, fin);

    do_start("s2");
    send("load", 1, 2, 0, 5, 2, 0, 8, 0, 0, 1, 32'h00812283, fin);
    send("store", 2, 2, 0, 0, 2, 6, 12, 1, 0, 1, 32'h00612623, fin);

    do_start("s3");
    send("br_neg", 3, 0, 0, 0, 1, 2, 13'h1FFC, 1, 0, 1, 32'hFE208EE3, fin);
    chk("br_neg_err", 32'(err_align), 0);
    do_start("s4");
    send("br_odd", 3, 0, 0, 0, 1, 2, 5, 1, 0, 0, 32'h0, fin);
    tick();
    chk("err_sticky", 32'(err_align), 1);
    do_start("s5_clear");

    for (int i = 0; i < 12 && !(i > 0 && fin); i++)
      send("depth", 1, 3, 0, i, i + 1, 0, i * 4, 0, 0, 0, 32'h0, fin);
    chk("depth_full_once", 32'(m_count), DEPTH);
    overflow_probe("ovf");

    // Start pulses while waiting in ACCEPT and across WRITE are ignored.
    do_start("s6");
    start = 1'b1;
    tick(); tick();
    start = 1'b0;
    chk("acc_start_addr", 32'(imem_addr), BASE);
    chk("acc_start_ready", 32'(in_ready), 1);
    send("inj0", 0, 7, 32, 9, 10, 11, 0, 0, 1, 0, 32'h0, fin);
    send("inj1", 2, 1, 0, 0, 4, 5, 13'h0FFF, 1, 1, 0, 32'h0, fin);

    // Asynchronous reset during the second WRITE of a three-word session.
    do_start("s7");
    send("pre_rst", 0, 0, 0, 1, 2, 3, 0, 0, 0, 0, 32'h0, fin);
    fmt = 2'b01; funct3 = 3'd2; rd = 5'd7; rs1 = 5'd8; imm = 13'd16; in_last = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rst_mid_we", 32'(imem_we), 1);
    #1 rst_n = 1'b0;
    #1 chk_reset("async_rst");
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk_reset("post_rst");
    do_start("s8");
    send("after_rst", 1, 0, 0, 4, 5, 0, 100, 1, 0, 0, 32'h0, fin);

    // Randomized sessions, some long enough to run into DEPTH.
    for (int s = 0; s < 8; s++) begin
      do_start("rnd_start");
      len = $urandom_range(1, 13);
      fin = 1'b0;
      for (int i = 0; i < int'(len) && !fin; i++) begin
        f = $urandom_range(0, 3);
        im = $urandom_range(0, 8191);
        send("rnd", f, $urandom_range(0, 7), $urandom_range(0, 127), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 31), im,
             (i == int'(len) - 1) && (len <= DEPTH), ($urandom_range(0, 3) == 0), 0, 32'h0, fin);
      end
      if (m_full) overflow_probe("rnd_ovf");
      chk("rnd_err", 32'(err_align), 32'(m_err));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
